// File: rtl/wght_update_seq.sv
// Layer-1 weight update sequencer: sweeps the W, U and B memories through a
// 3-stage read-modify-write pipeline, writing w - (grad >>> LR_SHIFT) with saturation.
module wght_update_seq #(
  parameter int ADDR_WIDTH = 12,
  parameter int WIDTH      = 32,
  parameter int FRAC       = 24,
  parameter int N_W        = 2809,
  parameter int N_U        = 2809,
  parameter int N_B        = 53,
  parameter int LR_SHIFT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  rd_en,
  output logic [1:0]            rd_sel,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [WIDTH-1:0]      i_wght,
  input  logic [WIDTH-1:0]      i_grad,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_w,
  output logic                  wr_u,
  output logic                  wr_b,
  output logic [WIDTH-1:0]      o_wght,
  output logic                  busy,
  output logic                  done
);

  if (N_W < 1 || N_U < 1 || N_B < 1 ||
      N_W > 2**ADDR_WIDTH || N_U > 2**ADDR_WIDTH || N_B > 2**ADDR_WIDTH) begin : g_bad_region_size
    $error("wght_update_seq: region word counts must be 1..2**ADDR_WIDTH");
  end
  if (LR_SHIFT < 0 || LR_SHIFT > WIDTH-1 || FRAC < 0 || FRAC > WIDTH) begin : g_bad_format
    $error("wght_update_seq: LR_SHIFT or FRAC out of range for WIDTH");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_W = ADDR_WIDTH'(N_W - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_U = ADDR_WIDTH'(N_U - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_B = ADDR_WIDTH'(N_B - 1);

  typedef enum logic [2:0] {IDLE, RUN_W, RUN_U, RUN_B, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic                    drain_cnt;
  logic [ADDR_WIDTH-1:0]   last_addr;
  logic                    at_last;
  logic                    running;

  logic                    s1_valid;
  logic [1:0]              s1_sel;
  logic [ADDR_WIDTH-1:0]   s1_addr;
  logic signed [WIDTH-1:0] delta;
  logic signed [WIDTH:0]   diff;
  logic [WIDTH-1:0]        upd_wght;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // The address counter wraps to 0 on each region's last word so the next region starts without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (running) rd_addr <= at_last ? '0 : rd_addr + 1'b1;
      else         rd_addr <= '0;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_comb begin
    last_addr = '0;
    case (state)
      RUN_W:   last_addr = LAST_W;
      RUN_U:   last_addr = LAST_U;
      RUN_B:   last_addr = LAST_B;
      default: last_addr = '0;
    endcase
  end

  assign running = (state == RUN_W) || (state == RUN_U) || (state == RUN_B);
  assign at_last = (rd_addr == last_addr);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN_W;
      RUN_W:   if (at_last) state_nxt = RUN_U;
      RUN_U:   if (at_last) state_nxt = RUN_B;
      RUN_B:   if (at_last) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en  = running;
    rd_sel = 2'd0;
    case (state)
      RUN_U:   rd_sel = 2'd1;
      RUN_B:   rd_sel = 2'd2;
      default: rd_sel = 2'd0;
    endcase
    busy = running || (state == DRAIN);
    done = (state == DONE);
  end

  // Stage 1 tracks which region/address the memory data arriving this cycle belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_sel   <= 2'd0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= rd_en;
      s1_sel   <= rd_sel;
      s1_addr  <= rd_addr;
    end
  end

  // One extra bit of headroom lets the subtraction detect overflow in either direction.
  always_comb begin
    delta = $signed(i_grad) >>> LR_SHIFT;
    diff  = $signed({i_wght[WIDTH-1], i_wght}) - $signed({delta[WIDTH-1], delta});
    if (diff[WIDTH] != diff[WIDTH-1])
      upd_wght = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      upd_wght = diff[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_w    <= 1'b0;
      wr_u    <= 1'b0;
      wr_b    <= 1'b0;
      wr_addr <= '0;
      o_wght  <= '0;
    end else begin
      wr_w    <= s1_valid && (s1_sel == 2'd0);
      wr_u    <= s1_valid && (s1_sel == 2'd1);
      wr_b    <= s1_valid && (s1_sel == 2'd2);
      wr_addr <= s1_valid ? s1_addr : '0;
      o_wght  <= s1_valid ? upd_wght : '0;
    end
  end

endmodule

// File: tb/tb_wght_update_seq.sv
// Scoreboard bench for wght_update_seq: a memory model feeds the DUT, expected
// reads and writes are queued at each start and a negedge monitor checks them.
module tb_wght_update_seq;

  localparam int AW    = 4;
  localparam int WIDTH = 32;
  localparam int N_W   = 4;
  localparam int N_U   = 3;
  localparam int N_B   = 2;
  localparam int LR    = 4;
  localparam int N_TOT = N_W + N_U + N_B;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             rd_en;
  logic [1:0]       rd_sel;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] i_wght;
  logic [WIDTH-1:0] i_grad;
  logic [AW-1:0]    wr_addr;
  logic             wr_w, wr_u, wr_b;
  logic [WIDTH-1:0] o_wght;
  logic             busy, done;

  wght_update_seq #(
    .ADDR_WIDTH(AW), .WIDTH(WIDTH), .FRAC(24),
    .N_W(N_W), .N_U(N_U), .N_B(N_B), .LR_SHIFT(LR)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .i_wght(i_wght), .i_grad(i_grad),
    .wr_addr(wr_addr), .wr_w(wr_w), .wr_u(wr_u), .wr_b(wr_b),
    .o_wght(o_wght), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    logic [1:0]       sel;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t rd_q[$];
  beat_t wr_q[$];

  logic [WIDTH-1:0] wmem [3][16];
  logic [WIDTH-1:0] gmem [3][16];

  int vectors      = 0;
  int miscompares  = 0;
  int t_start      = 0;
  bit sweep_active = 1'b0;
  bit expect_zero  = 1'b1;

  // Synchronous-read weight/gradient memories that also absorb the DUT's write-backs.
  always @(posedge clk) begin
    if (rd_en) begin
      i_wght <= wmem[rd_sel][rd_addr];
      i_grad <= gmem[rd_sel][rd_addr];
    end
    if (wr_w) wmem[0][wr_addr] <= o_wght;
    if (wr_u) wmem[1][wr_addr] <= o_wght;
    if (wr_b) wmem[2][wr_addr] <= o_wght;
  end

  function automatic logic [WIDTH-1:0] ref_update(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] g);
    longint wl, gl, r, hi, lo;
    logic [63:0] rv;
    wl = longint'($signed(w));
    gl = longint'($signed(g));
    r  = wl - (gl >>> LR);
    hi = (64'sd1 <<< (WIDTH-1)) - 1;
    lo = -(64'sd1 <<< (WIDTH-1));
    if (r > hi) return 32'h7FFF_FFFF;
    if (r < lo) return 32'h8000_0000;
    rv = r;
    return rv[WIDTH-1:0];
  endfunction

  function automatic int region_len(input int r);
    return (r == 0) ? N_W : (r == 1) ? N_U : N_B;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fill_const(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] g);
    for (int r = 0; r < 3; r++)
      for (int a = 0; a < 16; a++) begin
        wmem[r][a] = w;
        gmem[r][a] = g;
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < 3; r++)
      for (int a = 0; a < 16; a++) begin
        wmem[r][a] = $urandom;
        gmem[r][a] = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom >> 6);
      end
  endtask

  // Every read and write of the whole sweep is predicted up front from the memory image.
  task automatic begin_sweep();
    int idx;
    idx = 0;
    t_start = cyc;
    for (int r = 0; r < 3; r++)
      for (int a = 0; a < region_len(r); a++) begin
        rd_q.push_back('{t_start + 1 + idx, 2'(r), AW'(a), '0});
        wr_q.push_back('{t_start + 3 + idx, 2'(r), AW'(a), ref_update(wmem[r][a], gmem[r][a])});
        idx++;
      end
    sweep_active = 1'b1;
  endtask

  task automatic apply_stimulus(input bit poke_start, input int abort_at);
    int guard;
    bit aborted;
    guard = 0;
    aborted = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    begin_sweep();
    @(posedge clk); #1;
    start = 1'b0;
    while (sweep_active && guard < N_TOT + 20) begin
      start = poke_start && (cyc == t_start + 5);
      if (abort_at > 0 && cyc == t_start + abort_at) begin
        rst = 1'b0;
        rd_q.delete();
        wr_q.delete();
        sweep_active = 1'b0;
        expect_zero = 1'b1;
        aborted = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    if (sweep_active) begin
      check_output("done_timeout", 64'(guard), 64'(N_TOT + 3));
      rd_q.delete();
      wr_q.delete();
      sweep_active = 1'b0;
    end
    if (aborted) begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 expect_zero = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (expect_zero)
      check_output("outputs_zero",
                   64'({rd_en, rd_sel, rd_addr, wr_addr, wr_w, wr_u, wr_b, busy, done}),
                   64'd0);
    if (expect_zero)
      check_output("o_wght_zero", 64'(o_wght), 64'd0);

    if (rd_en) begin
      if (rd_q.size() == 0) check_output("rd_unexpected", 64'(rd_en), 64'd0);
      else begin
        e = rd_q.pop_front();
        check_output("rd_cycle", 64'(cyc), 64'(e.cyc));
        check_output("rd_sel", 64'(rd_sel), 64'(e.sel));
        check_output("rd_addr", 64'(rd_addr), 64'(e.addr));
      end
    end

    if (wr_w || wr_u || wr_b) begin
      check_output("wr_onehot", 64'($onehot({wr_b, wr_u, wr_w})), 64'd1);
      if (wr_q.size() == 0) check_output("wr_unexpected", 64'({wr_b, wr_u, wr_w}), 64'd0);
      else begin
        e = wr_q.pop_front();
        check_output("wr_cycle", 64'(cyc), 64'(e.cyc));
        check_output("wr_enables", 64'({wr_b, wr_u, wr_w}), 64'(3'b001 << e.sel));
        check_output("wr_addr", 64'(wr_addr), 64'(e.addr));
        check_output("o_wght", 64'(o_wght), 64'(e.data));
      end
    end

    if (sweep_active)
      check_output("busy", 64'(busy),
                   64'((cyc >= t_start + 1) && (cyc <= t_start + N_TOT + 2)));

    if (done) begin
      check_output("done_active", 64'(sweep_active), 64'd1);
      if (sweep_active) begin
        check_output("done_cycle", 64'(cyc - t_start), 64'(N_TOT + 3));
        check_output("leftover_beats", 64'(rd_q.size() + wr_q.size()), 64'd0);
      end
      sweep_active = 1'b0;
    end
  end

  initial begin
    fill_const(32'h0100_0000, 32'h0010_0000);
    rst = 1'b0;
    expect_zero = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 expect_zero = 1'b0;

    $display("[TB] basic sweep with constant weights");
    apply_stimulus(1'b0, 0);

    $display("[TB] saturation corners");
    fill_random();
    wmem[0][1] = 32'h7FFF_FFF0; gmem[0][1] = 32'h8000_0000;
    wmem[2][0] = 32'h8000_0010; gmem[2][0] = 32'h7FFF_FFFF;
    apply_stimulus(1'b0, 0);

    $display("[TB] random sweeps");
    for (int k = 0; k < 3; k++) begin
      fill_random();
      apply_stimulus(1'b0, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("[TB] start while busy");
    fill_random();
    apply_stimulus(1'b1, 0);
    repeat (4) @(posedge clk);

    $display("[TB] reset mid-sweep then fresh sweep");
    fill_random();
    apply_stimulus(1'b0, 6);
    apply_stimulus(1'b0, 0);
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wght_update_seq.md
Name: wght_update_seq

Overview:
- Downstream of the LSTM forward/backward top level; consumes its `update` pulse.
- Sweeps the layer-1 W, U and B weight memories as a 3-stage read-modify-write pipeline.
- Per word: w_new = w - (grad >>> LR_SHIFT), in signed Q(WIDTH-FRAC).FRAC with saturation.
- Drives the datapath's wr_addr_w_1/wr_w_1, wr_addr_u_1/wr_u_1 and wr_addr_b_1/wr_b_1 write ports.

Parameters:
- ADDR_WIDTH, 12, width of all address ports.
- WIDTH, 32, data word width, two's complement.
- FRAC, 24, fractional bits (informational only; no rescaling inside the block).
- N_W, 2809, word count of the W region (LAYR1_INPUT*LAYR1_CELL).
- N_U, 2809, word count of the U region (LAYR1_CELL*LAYR1_CELL).
- N_B, 53, word count of the B region (LAYR1_CELL).
- LR_SHIFT, 4, learning rate as an arithmetic right shift of the gradient (0..WIDTH-1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle update request (the datapath `update`).
- rd_en  out  1  read strobe to the weight and gradient memories.
- rd_sel  out  2  region being read: 0=W, 1=U, 2=B.
- rd_addr  out  ADDR_WIDTH  read address within the region.
- i_wght  in  WIDTH  old weight; valid 1 cycle after rd_en.
- i_grad  in  WIDTH  accumulated gradient; valid 1 cycle after rd_en.
- wr_addr  out  ADDR_WIDTH  write address (shared by all regions).
- wr_w  out  1  write enable, W region.
- wr_u  out  1  write enable, U region.
- wr_b  out  1  write enable, B region.
- o_wght  out  WIDTH  updated weight.
- busy  out  1  high from the first issue until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, async): state=IDLE, counters=0, and every output = 0 (rd_en, rd_sel, rd_addr, wr_addr, wr_w/u/b, o_wght, busy, done).
  - Reset mid-sweep aborts immediately; no further write is issued.
  - Memory contents are whatever was already written.
- FSM states: IDLE, RUN_W, RUN_U, RUN_B, DRAIN, DONE.
- IDLE → RUN_W on start=1. start is ignored in every other state, including DONE.
- RUN_x: rd_en=1 and rd_sel=region every cycle.
  - rd_addr counts 0..N_x-1, one per cycle.
  - After issuing address N_x-1: rd_addr returns to 0 and the FSM moves to the next region, with no bubble (W→U→B).
- RUN_B → DRAIN after address N_B-1. DRAIN lasts exactly 2 cycles with rd_en=0, then → DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then → IDLE.
- Pipeline:
  - Stage 0: issue (rd_en, rd_sel, rd_addr).
  - Stage 1: capture i_wght/i_grad and compute.
  - Stage 2: registered outputs wr_addr, o_wght and the enable matching the captured rd_sel.
  - Write lags its read by exactly 2 cycles.
  - Exactly one of wr_w/wr_u/wr_b is high per valid beat; all are 0 otherwise.
- Arithmetic:
  - delta = i_grad >>> LR_SHIFT (sign-extending).
  - diff = i_wght - delta, computed in WIDTH+1 bits.
  - If diff > 2^(WIDTH-1)-1, o_wght = 0x7FFF_FFFF; if diff < -2^(WIDTH-1), o_wght = 0x8000_FFFF-style minimum 0x8000_0000; else o_wght = diff[WIDTH-1:0].
  - No rounding (truncation by the shift).
- Timing: start at cycle T puts the first rd_en at T+1 and the first write at T+3. The last write is at T+N_W+N_U+N_B+2, and done is at T+N_W+N_U+N_B+3.
- busy is high from T+1 through the last write cycle inclusive.
- Write-after-read hazard: none. Each address is read once and written once, and the read precedes the write.
- Widths: counters are ADDR_WIDTH bits. N_W, N_U and N_B must each be at most 2^ADDR_WIDTH; this is checked by an elaboration-time assertion.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release with start=0 for 10 cycles → all outputs 0, no rd_en, no writes.
- Basic math: N_W=4, N_U=3, N_B=2, LR_SHIFT=4; every word has w=0x0100_0000, grad=0x0010_0000 → 9 writes of 0x00FF_0000. Addresses W 0..3, U 0..2, B 0..1. done at T+12.
- Saturation:
  - w=0x7FFF_FFF0, grad=0x8000_0000 → o_wght=0x7FFF_FFFF.
  - w=0x8000_0010, grad=0x7FFF_FFFF → o_wght=0x8000_0000.
- Region sequencing: check rd_sel goes 0,0,0,0,1,1,1,2,2 on consecutive cycles with no gap. Check wr_w/wr_u/wr_b follow the same pattern delayed 2 cycles, exactly one-hot on each beat.
- start while busy: pulse start at T+5 → no restart; total writes still 9; a single done pulse.
- Reset mid-operation: drop rst at T+6 → outputs 0 asynchronously, no writes afterwards. A fresh start then completes a full 9-write sweep.
